alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 76 +++++++
 tb/tb_alu.sv | 134 +++++++++++++
 2 files changed

// File: rtl/alu.sv
// Single-cycle 8-bit ALU. Result and flags are registered, and the result bus is
// tri-stated combinationally by in_enable_out.
module alu (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_A,
  input  logic [7:0] in_B,
  input  logic [2:0] op,
  input  logic       in_enable_out,
  output logic [7:0] out,
  output logic [3:0] flags
);
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_OR   = 3'b010,
    OP_AND  = 3'b011,
    OP_NOT  = 3'b100,
    OP_COMP = 3'b101,
    OP_SHR  = 3'b110,
    OP_SHL  = 3'b111
  } op_e;

  logic [7:0] res_d, res_q;
  logic [3:0] flags_d, flags_q;
  logic [8:0] sum9, diff9;
  logic       c_d, o_d;

  always_comb begin
    // bit 8 of the zero-extended difference is the unsigned borrow
    sum9  = {1'b0, in_A} + {1'b0, in_B};
    diff9 = {1'b0, in_A} - {1'b0, in_B};
    res_d = '0;
    c_d   = 1'b0;
    o_d   = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        res_d = sum9[7:0];
        c_d   = sum9[8];
        o_d   = (in_A[7] == in_B[7]) && (sum9[7] != in_A[7]);
      end
      OP_SUB: begin
        res_d = diff9[7:0];
        c_d   = diff9[8];
        o_d   = (in_A[7] != in_B[7]) && (diff9[7] != in_A[7]);
      end
      OP_OR:   res_d = in_A | in_B;
      OP_AND:  res_d = in_A & in_B;
      OP_NOT:  res_d = ~in_A;
      OP_COMP: res_d = (in_A == in_B) ? 8'h01 : 8'h00;
      OP_SHR: begin
        res_d = {1'b0, in_A[7:1]};
        c_d   = in_A[0];
      end
      OP_SHL: begin
        res_d = {in_A[6:0], 1'b0};
        c_d   = in_A[7];
      end
      default: res_d = '0;
    endcase
    flags_d = {c_d, res_d[7], o_d, (res_d == 8'h00)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign out   = in_enable_out ? res_q : 8'bzzzz_zzzz;
  assign flags = flags_q;
endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes expected {out, flags}, a monitor
// pops and compares one entry after each rising edge.
module tb_alu;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_A, in_B;
  logic [2:0] op;
  logic       in_enable_out;
  wire  [7:0] out;
  wire  [3:0] flags;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flg;
    logic       en;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  logic [7:0] last_res;
  logic [3:0] last_flg;

  alu dut (
    .clk(clk), .rst(rst), .in_A(in_A), .in_B(in_B), .op(op),
    .in_enable_out(in_enable_out), .out(out), .flags(flags)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on unsigned / signed interpretations.
  function automatic exp_t model(input int o, input int a, input int b);
    exp_t e;
    int r, c, v, sa, sb, s;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    c = 0; v = 0; r = 0;
    case (o)
      0: begin r = (a + b) % 256; c = (a + b > 255); s = sa + sb; v = (s > 127 || s < -128); end
      1: begin r = (a - b + 256) % 256; c = (a < b); s = sa - sb; v = (s > 127 || s < -128); end
      2: r = a | b;
      3: r = a & b;
      4: r = 255 - a;
      5: r = (a == b) ? 1 : 0;
      6: begin r = a / 2; c = a % 2; end
      default: begin r = (a * 2) % 256; c = (a >= 128); end
    endcase
    e.res = 8'(r);
    e.flg = {c[0], (r >= 128), v[0], (r == 0)};
    return e;
  endfunction

  task automatic issue(input int o, input int a, input int b, input bit en, input bit r, input string tag);
    exp_t e;
    @(negedge clk);
    rst = r; op = 3'(o); in_A = 8'(a); in_B = 8'(b); in_enable_out = en;
    if (r) begin e.res = 8'h00; e.flg = 4'b0000; end
    else e = model(o, a, b);
    e.en = en; e.tag = tag;
    q.push_back(e);
    last_res = e.res; last_flg = e.flg;
  endtask

  // Monitor: the result of the edge just taken is visible #1 later.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.en ? (out !== e.res) : (out !== 8'bzzzz_zzzz)) begin
        failures++;
        $display("FAIL %s out: got %h expected %h (en=%0d)", e.tag, out, e.res, e.en);
      end
      checks++;
      if (flags !== e.flg) begin
        failures++;
        $display("FAIL %s flags: got %b expected %b", e.tag, flags, e.flg);
      end
    end
  end

  initial begin
    rst = 1'b1; op = 3'd0; in_A = 8'h00; in_B = 8'h00; in_enable_out = 1'b1;
    issue(0, 8'h12, 8'h34, 1, 1, "reset");
    issue(0, 8'h00, 8'h00, 0, 1, "reset_z");
    // Directed vectors
    issue(0, 8'h40, 8'h41, 1, 0, "add_40_41");
    issue(0, 8'h84, 8'h81, 1, 0, "add_84_81");
    issue(0, 8'h40, 8'hC0, 1, 0, "add_40_c0");
    issue(1, 8'h01, 8'h02, 1, 0, "sub_01_02");
    issue(1, 8'h01, 8'h80, 1, 0, "sub_01_80");
    issue(1, 8'h80, 8'h01, 1, 0, "sub_80_01");
    issue(1, 8'h81, 8'h81, 1, 0, "sub_81_81");
    issue(2, 8'h03, 8'h11, 1, 0, "or");
    issue(3, 8'h53, 8'h11, 1, 0, "and");
    issue(4, 8'h53, 8'hFF, 1, 0, "not");
    issue(5, 8'h53, 8'h52, 1, 0, "comp_ne");
    issue(5, 8'h53, 8'h53, 1, 0, "comp_eq");
    issue(6, 8'h53, 8'h00, 1, 0, "shr");
    issue(7, 8'h53, 8'h00, 1, 0, "shl");
    issue(0, 8'h40, 8'h41, 0, 0, "add_hiz");
    issue(0, 8'h40, 8'h41, 1, 0, "add_pre_rst");
    issue(0, 8'h40, 8'h41, 1, 1, "mid_rst");
    issue(0, 8'h7F, 8'h01, 1, 0, "post_rst");

    // Enable gating is combinational: toggle between edges.
    @(posedge clk); #3;
    in_enable_out = 1'b0; #1;
    checks++;
    if (out !== 8'bzzzz_zzzz) begin failures++; $display("FAIL comb_hiz out: got %h expected zz", out); end
    checks++;
    if (flags !== last_flg) begin failures++; $display("FAIL comb_hiz flags: got %b expected %b", flags, last_flg); end
    in_enable_out = 1'b1; #1;
    checks++;
    if (out !== last_res) begin failures++; $display("FAIL comb_drive out: got %h expected %h", out, last_res); end

    // Randomized traffic, occasional reset and tri-state.
    for (int i = 0; i < 400; i++) begin
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            ($urandom_range(0, 7) != 0), ($urandom_range(0, 31) == 0), "rand");
    end

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
